// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressed data memory controller.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = DATA_W / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    typedef struct packed {
        logic              rvalid;
        logic              err;
        logic [DATA_W-1:0] data;
    } resp_t;

    // Byte lanes touched by an access of the given size at the given word offset
    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lo;
            SZ_HALF: lane_mask = 4'b0011 << lo;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_align.sv
// Lane steering for the data memory: byte enables, store replication,
// load extract/extension and access error decode.
module dmem_align
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rword_i,
    output logic [LANES-1:0]  be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c,
    output logic              err_c
);

    logic [1:0]        lo;
    logic              misalign;
    logic              range_err;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        lo        = addr_i[1:0];
        misalign  = ((size_i == SZ_HALF) && lo[0]) || ((size_i == SZ_WORD) && (lo != 2'b00));
        range_err = 64'(addr_i) >= 64'(DEPTH_BYTES);
        err_c     = (size_i == 2'b11) || misalign || range_err;

        // Erroneous accesses must never reach the array
        be_c = err_c ? 4'b0000 : lane_mask(size_i, lo);

        case (size_i)
            SZ_BYTE: wdata_c = {4{wdata_i[7:0]}};
            SZ_HALF: wdata_c = {2{wdata_i[15:0]}};
            default: wdata_c = wdata_i;
        endcase

        shifted = rword_i >> {lo, 3'b000};
        case (size_i)
            SZ_BYTE: rdata_c = unsigned_i ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: rdata_c = unsigned_i ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: rdata_c = rword_i;
        endcase
        if (err_c) begin
            rdata_c = '0;
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the MEM stage: req/ready handshake, post-reset
// clear sweep, pipelined in-order responses with error flagging.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES    = 1024,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned READ_LAT       = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              rvalid_o,
    output logic              err_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam state_e      RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              ready_q, ready_d;
    resp_t             pipe_q [READ_LAT];
    resp_t             pipe_d [READ_LAT];
    logic [DATA_W-1:0] mem_q  [WORDS];

    logic              accept;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] rword;
    logic [LANES-1:0]  al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    logic              al_err;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [LANES-1:0]  mem_be;
    logic [DATA_W-1:0] mem_wdata;

    assign accept  = req_i & ready_q;
    assign acc_idx = addr_i[IDX_W+1:2];
    assign rword   = mem_q[acc_idx];

    dmem_align #(
        .ADDR_W      (ADDR_W),
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_align (
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (data_i),
        .rword_i    (rword),
        .be_c       (al_be),
        .wdata_c    (al_wdata),
        .rdata_c    (al_rdata),
        .err_c      (al_err)
    );

    // Clear sweep / idle FSM and array write port selection
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_idx   = acc_idx;
        mem_be    = al_be;
        mem_wdata = al_wdata;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_cnt_q;
                mem_be    = 4'b1111;
                mem_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IDX_W'(WORDS - 1)) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end
            end
            IDLE: begin
                mem_we = accept & we_i;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // Every accepted request takes one response slot; stores only carry err
    always_comb begin
        pipe_d[0].rvalid = accept & ~we_i;
        pipe_d[0].err    = accept & al_err;
        pipe_d[0].data   = (accept & ~we_i) ? al_rdata : '0;
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
            pipe_q    <= pipe_d;
        end
    end

    // Array contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign ready_o  = ready_q;
    assign rvalid_o = pipe_q[READ_LAT-1].rvalid;
    assign err_o    = pipe_q[READ_LAT-1].err;
    assign data_o   = pipe_q[READ_LAT-1].data;

endmodule
